// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
// Shared definitions for the memory/IO bus controller:
//   state_t      - controller FSM states
//   win_entry_t  - one address-window descriptor
//   WIN_MAP      - default window table (8 windows of 8 KB)
//   win_lookup   - window index -> descriptor, out-of-table indices are unmapped
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    FAULT,
    ABORT
  } state_t;

  localparam int unsigned MAP_ADDR_W  = 16;
  localparam int unsigned MAP_CS_W    = 2;
  localparam int unsigned MAP_WAIT_W  = 4;
  localparam int unsigned MAP_ENTRIES = 8;
  localparam int unsigned MAP_IDX_W   = $clog2(MAP_ENTRIES);

  typedef struct packed {
    logic                  valid;
    logic [MAP_CS_W-1:0]   cs_idx;
    logic                  writable;
    logic [MAP_WAIT_W-1:0] wait_states;
    logic [MAP_ADDR_W-1:0] base;
  } win_entry_t;

  localparam win_entry_t NO_WIN  = '{valid: 1'b0, cs_idx: 2'd0, writable: 1'b0,
                                     wait_states: 4'd0, base: 16'h0000};
  localparam win_entry_t ROM_WIN = '{valid: 1'b1, cs_idx: 2'd0, writable: 1'b0,
                                     wait_states: 4'd1, base: 16'h0000};
  localparam win_entry_t RAM_WIN = '{valid: 1'b1, cs_idx: 2'd1, writable: 1'b1,
                                     wait_states: 4'd0, base: 16'h2000};
  localparam win_entry_t IO_WIN  = '{valid: 1'b1, cs_idx: 2'd2, writable: 1'b1,
                                     wait_states: 4'd2, base: 16'hE000};

  // Index 0 is the leftmost element of the concatenation.
  localparam win_entry_t [0:MAP_ENTRIES-1] WIN_MAP = {
    ROM_WIN, RAM_WIN, NO_WIN, NO_WIN, NO_WIN, NO_WIN, NO_WIN, IO_WIN
  };

  function automatic win_entry_t win_lookup(input int unsigned w);
    win_entry_t e;
    if (w < MAP_ENTRIES) e = WIN_MAP[w[MAP_IDX_W-1:0]];
    else                 e = NO_WIN;
    return e;
  endfunction

endpackage

// File: rtl/mem_win_decode.sv
// mem_win_decode
// Combinational address decoder: selects the window from the top WIN_BITS
// address bits, looks it up in WIN_MAP and forms the device-relative address.
// Ports:
//   addr        in  CPU address
//   win_valid   out window is mapped
//   win_cs      out chip-select index for the window
//   win_wr      out window accepts writes
//   win_wait    out programmed wait states
//   dev_addr    out addr - window base (mod 2**ADDR_W)
module mem_win_decode
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned WIN_BITS = 3
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic                  win_valid,
  output logic [MAP_CS_W-1:0]   win_cs,
  output logic                  win_wr,
  output logic [MAP_WAIT_W-1:0] win_wait,
  output logic [ADDR_W-1:0]     dev_addr
);

  logic [WIN_BITS-1:0] win;
  win_entry_t          entry;
  logic [ADDR_W-1:0]   base;

  always_comb begin
    win       = addr[ADDR_W-1 -: WIN_BITS];
    entry     = win_lookup(32'(win));
    base      = ADDR_W'(entry.base);
    win_valid = entry.valid;
    win_cs    = entry.cs_idx;
    win_wr    = entry.writable;
    win_wait  = entry.wait_states;
    dev_addr  = addr - base;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
// Clocked memory/IO bus controller. Accepts single-beat CPU requests over a
// req/ack handshake, decodes the target window, and runs a
// SETUP -> STROBE (wait states + ext_wait stretch) -> HOLD cycle on one
// active-low chip select. Unmapped windows and writes to read-only windows
// complete immediately with err; an ext_wait stretch beyond TIMEOUT aborts.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req, we, addr,     CPU request, sampled only in IDLE
//   wdata
//   rdata              read data, valid with ack of a successful read
//   ack, err, busy     completion pulse, failure qualifier, non-idle flag
//   ext_addr           device-relative address latched at accept
//   ext_data           bidirectional device data bus
//   cs_n, oe_n, we_n   active-low chip selects and strobes
//   ext_wait           device stretch request
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WIN_BITS = 3,
  parameter int unsigned NUM_CS   = 3,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] ext_addr,
  inout  logic [DATA_W-1:0] ext_data,
  output logic [NUM_CS-1:0] cs_n,
  output logic              oe_n,
  output logic              we_n,
  input  logic              ext_wait
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_t state_q, state_d;

  logic                  win_valid;
  logic [MAP_CS_W-1:0]   win_cs;
  logic                  win_wr;
  logic [MAP_WAIT_W-1:0] win_wait;
  logic [ADDR_W-1:0]     dev_addr;

  logic                  we_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [ADDR_W-1:0]     ext_addr_q;
  logic [MAP_CS_W-1:0]   cs_idx_q;
  logic [MAP_WAIT_W-1:0] wait_cnt_q;
  logic [TO_W-1:0]       to_cnt_q;
  logic [DATA_W-1:0]     rdata_q;

  logic                  reject;
  logic                  cs_active;
  logic                  drive_en;

  mem_win_decode #(
    .ADDR_W   (ADDR_W),
    .WIN_BITS (WIN_BITS)
  ) u_decode (
    .addr      (addr),
    .win_valid (win_valid),
    .win_cs    (win_cs),
    .win_wr    (win_wr),
    .win_wait  (win_wait),
    .dev_addr  (dev_addr)
  );

  always_comb begin
    reject = !win_valid || (we && !win_wr);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (req) state_d = reject ? FAULT : SETUP;
      SETUP:  state_d = STROBE;
      STROBE: begin
        // Programmed wait states run first; ext_wait only counts once they expire.
        if (wait_cnt_q == '0) begin
          if (!ext_wait)                          state_d = HOLD;
          else if (to_cnt_q == TO_W'(TIMEOUT))    state_d = ABORT;
        end
      end
      HOLD, FAULT, ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait/timeout counters and read capture.
  // wait_cnt is loaded at accept rather than in SETUP; SETUP never reads it,
  // so the strobe timing is identical.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ext_addr_q <= '0;
      cs_idx_q   <= '0;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !reject) begin
            we_q       <= we;
            wdata_q    <= wdata;
            ext_addr_q <= dev_addr;
            cs_idx_q   <= win_cs;
            wait_cnt_q <= win_wait;
            to_cnt_q   <= '0;
          end
        end
        STROBE: begin
          if (wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - MAP_WAIT_W'(1);
          end else if (ext_wait) begin
            if (to_cnt_q != TO_W'(TIMEOUT)) to_cnt_q <= to_cnt_q + TO_W'(1);
          end else if (!we_q) begin
            rdata_q <= ext_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    cs_active = 1'b0;
    drive_en  = 1'b0;
    oe_n      = 1'b1;
    we_n      = 1'b1;
    ack       = 1'b0;
    err       = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      SETUP: begin
        cs_active = 1'b1;
        drive_en  = we_q;
      end
      STROBE: begin
        cs_active = 1'b1;
        drive_en  = we_q;
        oe_n      = we_q;
        we_n      = !we_q;
      end
      HOLD: begin
        cs_active = 1'b1;
        drive_en  = we_q;
        ack       = 1'b1;
      end
      FAULT, ABORT: begin
        ack = 1'b1;
        err = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cs_n = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (cs_active && (32'(cs_idx_q) == i)) cs_n[i] = 1'b0;
    end
  end

  assign ext_data = drive_en ? wdata_q : 'z;
  assign rdata    = rdata_q;
  assign ext_addr = ext_addr_q;

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Parametrised, clocked memory/IO bus controller that replaces the combinational ROM/RAM decoder. It accepts single-beat read/write requests from the CPU memory stage over a req/ack handshake. It decodes the address into one of 2**WIN_BITS windows using a table in a shared package, then drives one active-low chip select with setup, strobe, wait-state and hold phases. It returns read data or an error (unmapped window, write to read-only window, external-wait timeout) with a one-cycle ack.

Parameters:
ADDR_W, 16, CPU/external address width
DATA_W, 8, data bus width
WIN_BITS, 3, upper address bits selecting a window (8 windows of 8 KB at default)
NUM_CS, 3, number of chip-select outputs
TIMEOUT, 15, max cycles ext_wait may stretch a strobe before abort (width derived via $clog2(TIMEOUT+1))

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
req  input  1  CPU request, sampled only in IDLE
we  input  1  1=write, 0=read; sampled with req
addr  input  ADDR_W  CPU address; sampled with req
wdata  input  DATA_W  write data; sampled with req
rdata  output  DATA_W  read data, valid during ack of a successful read
ack  output  1  one-cycle completion pulse
err  output  1  qualifies ack: access failed
busy  output  1  high whenever state != IDLE
ext_addr  output  ADDR_W  device-relative address
ext_data  inout  DATA_W  external data bus
cs_n  output  NUM_CS  active-low chip selects, at most one low
oe_n  output  1  active-low read strobe
we_n  output  1  active-low write strobe
ext_wait  input  1  device stretch request, active high

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE; cs_n all 1; oe_n=we_n=1; ack=err=busy=0; rdata=0; ext_addr=0; ext_data released (Z); wait/timeout counters=0. Reset mid-access aborts with no ack.
- Decode: w = addr[ADDR_W-1 -: WIN_BITS]; entry = WIN_MAP[w] {valid, cs_idx, writable, wait_states, base}. ext_addr = addr - base, modulo 2**ADDR_W, latched at accept.
- IDLE: on req=1: if !valid, or we && !writable -> FAULT; else latch we/addr/wdata/entry -> SETUP. req=0: stay.
- FAULT: ack=1, err=1, no cs/strobe activity, 1 cycle -> IDLE.
- SETUP (1 cycle): cs_n[cs_idx]=0, strobes high, ext_addr driven; on writes ext_data driven with wdata from this cycle through HOLD. wait_cnt loaded with wait_states. -> STROBE.
- STROBE: oe_n=0 (read) or we_n=0 (write). If wait_cnt>0: decrement, stay. If wait_cnt==0 and ext_wait=1: increment to_cnt and stay; if to_cnt==TIMEOUT -> ABORT. If wait_cnt==0 and ext_wait=0: capture ext_data into rdata (reads) -> HOLD. Minimum length 1 cycle.
- HOLD (1 cycle): strobe high, cs still low, write data still driven; ack=1, err=0 -> IDLE.
- ABORT (1 cycle): cs/strobes high, bus released, ack=1, err=1, rdata unchanged -> IDLE.
- Latency with ext_wait=0: req sampled at edge E0; ack high in the cycle after edge E0+2+W (W = wait_states). Fault ack is in the cycle after E0.
- req while busy is ignored and is not queued. The CPU holds req until ack. A new req in the cycle after ack is accepted, giving back-to-back accesses one IDLE cycle apart.
- ext_data is driven only for writes in SETUP/STROBE/HOLD; released in all other states.
- busy=1 in all non-IDLE states, including FAULT and ABORT.

Decomposition:
- Package mem_bus_pkg: state enum (IDLE, SETUP, STROBE, HOLD, FAULT, ABORT); win_entry_t struct; WIN_MAP constant.
- Default WIN_MAP:
  - w0: ROM, cs0, read-only, wait 1, base 0x0000
  - w1: RAM, cs1, rw, wait 0, base 0x2000
  - w2–w6: invalid
  - w7: IO, cs2, rw, wait 2, base 0xE000
- One sub-module, mem_win_decode: combinational address -> entry lookup and ext_addr subtraction. The FSM stays in mem_bus_ctrl.

Test Plan:
- Read 0x0010 (ROM), device returns 0xA5, ext_wait=0 -> cs_n=3'b110, oe_n low 2 cycles, ext_addr=0x0010, ack+rdata=0xA5 at E0+3 cycles, err=0.
- Write 0x2345 data 0x5A -> cs_n=3'b101, we_n low 1 cycle, ext_addr=0x0345, ext_data=0x5A SETUP..HOLD, ack at E0+2, err=0.
- Write 0x0100 (ROM) and read 0x4000 (unmapped) -> no cs/strobe, ack=1 err=1 in cycle after accept, busy high exactly 1 cycle.
- Read 0xE002 with ext_wait held 4 cycles past wait_states -> oe_n low 2+1+4 cycles, ack err=0. Repeat with ext_wait stuck high -> ABORT after 15 stretch cycles, ack err=1, cs_n all 1.
- Back-to-back: req held high through write 0x2000 then read 0x2000 -> second access starts one IDLE cycle after first ack, rdata matches written value from RAM model.
- Assert rst_n=0 during STROBE of an IO read -> next edge cs_n=3'b111, oe_n=1, bus Z, no ack; fresh request after reset completes normally.
